vga_pixel_streamer: RTL and testbench

- Upstream neighbour of the VGA output stage: generates HSync/VSync timing and drives RED/GREEN/BLUE from a valid/ready pixel stream.
- Pixels are consumed in raster order during the active region only; blanking outputs are black.
- All outputs are registered on clk. The bus is sampled at posedge clk by the output monitor.

---
 rtl/VGA_item_pack.sv | 28 ++
 rtl/vga_timing_counter.sv | 76 +++++++
 rtl/vga_pixel_streamer.sv | 135 +++++++++++++
 tb/tb_vga_pixel_streamer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/VGA_item_pack.sv
// Shared definitions for the VGA pixel streamer.
// - COLOR_WIDTH: bits per colour channel.
// - DEF_*: default 640x480@60 timing (pixel clocks / lines).
// - vga_pixel_t: one RGB pixel, used both for the incoming stream and the
//   registered output colour.
package VGA_item_pack;

   localparam int COLOR_WIDTH = 4;

   // 640x480@60 horizontal timing, in pixel clocks
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;

   // 640x480@60 vertical timing, in lines
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef struct packed {
      logic [COLOR_WIDTH-1:0] red;
      logic [COLOR_WIDTH-1:0] green;
      logic [COLOR_WIDTH-1:0] blue;
   } vga_pixel_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position counters for the VGA pixel streamer.
// Ports:
//   clk, rst     - pixel clock, synchronous active-high reset
//   en           - run enable; low parks the counters at (0,0)
//   h_cnt, v_cnt - current raster position
//   active       - position is inside the visible area
//   hs_on, vs_on - position is inside the horizontal / vertical sync pulse
//   frame_first  - position is the first pixel of a frame (0,0)
module vga_timing_counter
   import VGA_item_pack::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          active,
   output logic          hs_on,
   output logic          vs_on,
   output logic          frame_first
);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;

   // The line counter only moves on the last pixel of a line, so both
   // counters wrap on the same clock at the end of a frame.
   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign h_cnt       = h_cnt_q;
   assign v_cnt       = v_cnt_q;
   assign active      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
   assign hs_on       = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
   assign vs_on       = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
   assign frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_pixel_streamer.sv
// Turns a valid/ready pixel stream into registered VGA sync + colour outputs.
// Ports:
//   clk, rst           - pixel clock, synchronous active-high reset
//   en                 - run enable; low idles the outputs and restarts the frame
//   in_valid/in_ready  - pixel stream handshake (ready only on active pixels)
//   in_red/green/blue  - pixel colour
//   underflow_clr      - clears the sticky underflow flag
//   HSync, VSync       - sync outputs, polarity set by SYNC_ACTIVE_LOW
//   RED, GREEN, BLUE   - colour outputs (black in blanking)
//   frame_start        - pulse alongside the first output pixel of a frame
//   underflow          - sticky: an active pixel had no valid input
module vga_pixel_streamer
   import VGA_item_pack::*;
#(
   parameter int H_ACTIVE        = DEF_H_ACTIVE,
   parameter int H_FP            = DEF_H_FP,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BP            = DEF_H_BP,
   parameter int V_ACTIVE        = DEF_V_ACTIVE,
   parameter int V_FP            = DEF_V_FP,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BP            = DEF_V_BP,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COLOR_WIDTH-1:0] in_red,
   input  logic [COLOR_WIDTH-1:0] in_green,
   input  logic [COLOR_WIDTH-1:0] in_blue,
   input  logic                   underflow_clr,
   output logic                   HSync,
   output logic                   VSync,
   output logic [COLOR_WIDTH-1:0] RED,
   output logic [COLOR_WIDTH-1:0] GREEN,
   output logic [COLOR_WIDTH-1:0] BLUE,
   output logic                   frame_start,
   output logic                   underflow
);

   localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          active, hs_on, vs_on, frame_first;
   logic          xfer;
   vga_pixel_t    pix_in;

   vga_pixel_t rgb_q, rgb_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       fs_q, fs_d;
   logic       uf_q, uf_d;

   vga_timing_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .active      (active),
      .hs_on       (hs_on),
      .vs_on       (vs_on),
      .frame_first (frame_first)
   );

   // Raw position is only a debug aid at this level.
   logic unused_cnt;
   assign unused_cnt = ^{h_cnt, v_cnt};

   assign pix_in = '{red: in_red, green: in_green, blue: in_blue};

   // Ready follows the raster, never the upstream valid. The rst term keeps
   // ready low while the counters may still hold a mid-frame position.
   assign in_ready = en && active && !rst;
   assign xfer     = in_valid && in_ready;

   // Next-state values for a running (enabled, not in reset) cycle.
   always_comb begin
      rgb_d   = xfer ? pix_in : '0;
      hsync_d = hs_on ^ SYNC_ACTIVE_LOW;
      vsync_d = vs_on ^ SYNC_ACTIVE_LOW;
      fs_d    = frame_first;
      uf_d    = uf_q;
      // A new starvation beats a simultaneous clear.
      if (active && !in_valid) begin
         uf_d = 1'b1;
      end else if (underflow_clr) begin
         uf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q   <= '0;
         hsync_q <= SYNC_ACTIVE_LOW;
         vsync_q <= SYNC_ACTIVE_LOW;
         fs_q    <= 1'b0;
         uf_q    <= 1'b0;
      end else if (!en) begin
         // Idle looks like reset, but the underflow history is kept.
         rgb_q   <= '0;
         hsync_q <= SYNC_ACTIVE_LOW;
         vsync_q <= SYNC_ACTIVE_LOW;
         fs_q    <= 1'b0;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         fs_q    <= fs_d;
         uf_q    <= uf_d;
      end
   end

   assign RED         = rgb_q.red;
   assign GREEN       = rgb_q.green;
   assign BLUE        = rgb_q.blue;
   assign HSync       = hsync_q;
   assign VSync       = vsync_q;
   assign frame_start = fs_q;
   assign underflow   = uf_q;

endmodule

// File: tb/tb_vga_pixel_streamer.sv
// Directed bench for vga_pixel_streamer using a tiny raster:
// H 4/1/2/1 (8 clocks per line), V 3/1/1/1 (6 lines, 48 clocks per frame).
module tb_vga_pixel_streamer;
   import VGA_item_pack::*;

   logic       clk = 1'b0;
   logic       rst, en, in_valid, underflow_clr;
   logic [3:0] in_red, in_green, in_blue;
   logic       in_ready, HSync, VSync, frame_start, underflow;
   logic [3:0] RED, GREEN, BLUE;
   logic [11:0] rgb_o;

   assign rgb_o = {RED, GREEN, BLUE};

   always #5 clk = ~clk;

   vga_pixel_streamer #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
      .underflow_clr(underflow_clr),
      .HSync(HSync), .VSync(VSync),
      .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
      .frame_start(frame_start), .underflow(underflow)
   );

   int total = 0;
   int bad   = 0;
   int th = 0, tv = 0;   // position the next clock edge will process
   int ph = 0, pv = 0;   // position the outputs currently show
   int cyc_no = 0;

   // One clock edge; tracks the raster position from rst/en seen at the edge.
   task automatic step();
      int  h0, v0;
      bit  rs, e;
      h0 = th; v0 = tv; rs = rst; e = en;
      if (in_valid && in_ready)
         $display("xfer  cyc=%0d h=%0d v=%0d rgb=%h%h%h", cyc_no, h0, v0, in_red, in_green, in_blue);
      @(posedge clk);
      #1;
      ph = h0; pv = v0; cyc_no++;
      if (rs || !e) begin
         th = 0; tv = 0;
      end else if (th == 7) begin
         th = 0;
         tv = (tv == 5) ? 0 : tv + 1;
      end else begin
         th++;
      end
   endtask

   // Advance with in_valid high until the bench position reaches (h,v).
   task automatic goto(input int h, input int v, output bit ok);
      ok = 1'b1;
      for (int n = 0; n < 100 && !(th == h && tv == v); n++) begin
         in_valid = 1'b1; in_red = 4'h1; in_green = 4'h2; in_blue = 4'h3;
         step();
      end
      if (!(th == h && tv == v)) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; in_valid = 1'b1; underflow_clr = 1'b0;
      in_red = 4'h5; in_green = 4'h6; in_blue = 4'h7;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
         step();
         total++; if (HSync !== 1'b1) begin bad++; $display("FAIL reset_hsync: got %b want 1", HSync); end
         total++; if (VSync !== 1'b1) begin bad++; $display("FAIL reset_vsync: got %b want 1", VSync); end
         total++; if (rgb_o !== 12'h000) begin bad++; $display("FAIL reset_rgb: got %h want 000", rgb_o); end
         total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs: got %b want 0", frame_start); end
         total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_uf: got %b want 0", underflow); end
      end
      rst = 1'b0;
   endtask

   task automatic test_full_frame();
      int   n_ready = 0, n_fs = 0;
      logic exp_rdy;
      logic [3:0] d;
      for (int k = 0; k < 48; k++) begin
         d = 4'(k + 1);
         in_valid = 1'b1; in_red = d; in_green = ~d; in_blue = d ^ 4'h5;
         exp_rdy = (th < 4) && (tv < 3);
         #1;
         total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL frame_ready h=%0d v=%0d: got %b want %b", th, tv, in_ready, exp_rdy); end
         if (in_ready === 1'b1) n_ready++;
         step();
         total++; if (rgb_o !== (exp_rdy ? {d, ~d, d ^ 4'h5} : 12'h000)) begin bad++; $display("FAIL frame_rgb h=%0d v=%0d: got %h", ph, pv, rgb_o); end
         total++; if (HSync !== !(ph == 5 || ph == 6)) begin bad++; $display("FAIL frame_hsync h=%0d: got %b", ph, HSync); end
         total++; if (VSync !== !(pv == 4)) begin bad++; $display("FAIL frame_vsync v=%0d: got %b", pv, VSync); end
         total++; if (frame_start !== (ph == 0 && pv == 0)) begin bad++; $display("FAIL frame_fs h=%0d v=%0d: got %b", ph, pv, frame_start); end
         if (frame_start === 1'b1) n_fs++;
      end
      total++; if (n_ready != 12) begin bad++; $display("FAIL frame_xfers: got %0d want 12", n_ready); end
      total++; if (n_fs != 1) begin bad++; $display("FAIL frame_fs_count: got %0d want 1", n_fs); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL frame_uf: got %b want 0", underflow); end
   endtask

   task automatic test_starvation();
      bit ok;
      goto(2, 1, ok);
      total++; if (!ok) begin bad++; $display("FAIL starve_goto: position (2,1) not reached, at (%0d,%0d)", th, tv); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL starve_pre_uf: got %b want 0", underflow); end
      in_valid = 1'b0; in_red = 4'hA; in_green = 4'hB; in_blue = 4'hC;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL starve_ready: got %b want 1", in_ready); end
      step();
      total++; if (rgb_o !== 12'h000) begin bad++; $display("FAIL starve_rgb: got %h want 000", rgb_o); end
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL starve_uf_set: got %b want 1", underflow); end
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (underflow !== 1'b1) begin bad++; $display("FAIL starve_uf_hold: got %b want 1", underflow); end
      end
      underflow_clr = 1'b1;
      step();
      underflow_clr = 1'b0;
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL starve_uf_clr: got %b want 0", underflow); end
      goto(0, 2, ok);
      total++; if (!ok) begin bad++; $display("FAIL starve_goto2: position (0,2) not reached, at (%0d,%0d)", th, tv); end
      in_valid = 1'b0; underflow_clr = 1'b1;
      step();
      in_valid = 1'b1; underflow_clr = 1'b0;
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL starve_set_wins: got %b want 1", underflow); end
      total++; if (rgb_o !== 12'h000) begin bad++; $display("FAIL starve_rgb2: got %h want 000", rgb_o); end
   endtask

   task automatic test_blanking();
      bit ok;
      goto(4, 2, ok);
      total++; if (!ok) begin bad++; $display("FAIL blank_goto: position (4,2) not reached, at (%0d,%0d)", th, tv); end
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_red = 4'hF; in_green = 4'hF; in_blue = 4'hF;
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL blank_ready h=%0d: got %b want 0", th, in_ready); end
         step();
         total++; if (rgb_o !== 12'h000) begin bad++; $display("FAIL blank_rgb h=%0d: got %h want 000", ph, rgb_o); end
      end
   endtask

   task automatic test_en_drop();
      bit ok;
      goto(3, 2, ok);
      total++; if (!ok) begin bad++; $display("FAIL endrop_goto: position (3,2) not reached, at (%0d,%0d)", th, tv); end
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_red = 4'h9; in_green = 4'h8; in_blue = 4'h7;
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL endrop_ready: got %b want 0", in_ready); end
         step();
         total++; if (HSync !== 1'b1) begin bad++; $display("FAIL endrop_hsync: got %b want 1", HSync); end
         total++; if (VSync !== 1'b1) begin bad++; $display("FAIL endrop_vsync: got %b want 1", VSync); end
         total++; if (rgb_o !== 12'h000) begin bad++; $display("FAIL endrop_rgb: got %h want 000", rgb_o); end
         total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL endrop_fs: got %b want 0", frame_start); end
         total++; if (underflow !== 1'b1) begin bad++; $display("FAIL endrop_uf: got %b want 1", underflow); end
      end
      en = 1'b1; in_red = 4'h4; in_green = 4'h5; in_blue = 4'h6;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL enrise_ready: got %b want 1", in_ready); end
      step();
      total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL enrise_fs: got %b want 1", frame_start); end
      total++; if (rgb_o !== 12'h456) begin bad++; $display("FAIL enrise_rgb: got %h want 456", rgb_o); end
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL enrise_uf: got %b want 1", underflow); end
   endtask

   task automatic test_wrap();
      int   last_fs = -1, n_fs = 0;
      logic exp_rdy;
      logic [3:0] d;
      for (int k = 0; k < 150; k++) begin
         d = 4'(k * 3);
         in_valid = 1'b1; in_red = d; in_green = d + 4'h1; in_blue = ~d;
         exp_rdy = (th < 4) && (tv < 3);
         step();
         total++; if (rgb_o !== (exp_rdy ? {d, d + 4'h1, ~d} : 12'h000)) begin bad++; $display("FAIL wrap_rgb h=%0d v=%0d: got %h", ph, pv, rgb_o); end
         total++; if ({HSync, VSync} !== {!(ph == 5 || ph == 6), !(pv == 4)}) begin bad++; $display("FAIL wrap_sync h=%0d v=%0d: got %b%b", ph, pv, HSync, VSync); end
         if (frame_start === 1'b1) begin
            n_fs++;
            if (last_fs >= 0) begin
               total++; if (cyc_no - last_fs != 48) begin bad++; $display("FAIL wrap_fs_spacing: got %0d want 48", cyc_no - last_fs); end
            end
            last_fs = cyc_no;
         end
      end
      total++; if (n_fs != 3) begin bad++; $display("FAIL wrap_fs_count: got %0d want 3", n_fs); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; underflow_clr = 1'b0;
      in_red = '0; in_green = '0; in_blue = '0;
      test_reset();
      test_full_frame();
      test_starvation();
      test_blanking();
      test_en_drop();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
